// File: rtl/div_sched_pkg.sv
// Shared types and default sizing for the divided-tick slot scheduler.
package div_sched_pkg;
  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_DIV_W     = 10;
  localparam int DEF_CNT_W     = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_core.sv
// Loadable down-counter; load wins over decrement, and it holds at zero.
module div_core #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_value,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                      r_cnt <= '0;
    else if (i_load)                   r_cnt <= i_load_val;
    else if (i_dec && (r_cnt != '0))   r_cnt <= r_cnt - W'(1);
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == '0);
endmodule

// File: rtl/div_sched.sv
// Walks a table of (divide, count) slots, emitting count ticks of period D+1
// per active slot, optionally looping over the active slots until stopped.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int DIV_W     = DEF_DIV_W,
  parameter int CNT_W     = DEF_CNT_W,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_addr,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_cnt,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic              tick,
  output logic [SLOT_W-1:0] slot,
  output logic              busy,
  output logic              done
);
  state_t                              r_state;
  logic [SLOT_W-1:0]                   r_slot;
  logic [CNT_W-1:0]                    r_left;
  logic [NUM_SLOTS-1:0][DIV_W-1:0]     r_div;
  logic [NUM_SLOTS-1:0][CNT_W-1:0]     r_cnt;

  logic [NUM_SLOTS-1:0] w_act;
  logic                 w_any, w_has_hi, w_nxt_ok, w_zero, w_last;
  logic [SLOT_W-1:0]    w_first, w_hi, w_nxt, w_ld_slot;
  logic                 w_start_run, w_ld, w_dec;
  logic [DIV_W-1:0]     w_div_val;

  genvar g;
  generate
    for (g = 0; g < NUM_SLOTS; g++) begin : g_act
      assign w_act[g] = (r_cnt[g] != '0);
    end
  endgenerate

  // Descending scan so the final hit is the lowest qualifying index.
  always_comb begin
    w_any    = 1'b0;
    w_first  = '0;
    w_has_hi = 1'b0;
    w_hi     = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_any   = 1'b1;
        w_first = SLOT_W'(i);
        if (i > int'(r_slot)) begin
          w_has_hi = 1'b1;
          w_hi     = SLOT_W'(i);
        end
      end
    end
  end

  assign w_nxt       = w_has_hi ? w_hi : w_first;
  assign w_nxt_ok    = w_has_hi | (loop_en & w_any);
  assign w_last      = (r_left <= CNT_W'(1));
  assign w_start_run = (r_state == IDLE) && start && !stop && w_any;
  assign w_ld_slot   = (r_state == IDLE) ? w_first : (w_last ? w_nxt : r_slot);
  assign w_ld        = w_start_run ||
                       ((r_state == RUN) && !stop && w_zero && (!w_last || w_nxt_ok));
  assign w_dec       = (r_state == RUN) && !stop && !w_zero;
  assign w_div_val   = r_div[w_ld_slot];

  div_core #(.W(DIV_W)) u_core (
    .i_clk      (sys_clk),
    .i_rst_n    (sys_rst_n),
    .i_load     (w_ld),
    .i_load_val (w_div_val),
    .i_dec      (w_dec),
    .o_value    (),
    .o_zero     (w_zero)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_left  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_div[i] <= DIV_W'(1);
        r_cnt[i] <= '0;
      end
    end else begin
      // Table is frozen while running so slot loads always see stable values.
      if (cfg_we && (r_state != RUN)) begin
        r_div[cfg_addr] <= cfg_div;
        r_cnt[cfg_addr] <= cfg_cnt;
      end
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            if (w_any) begin
              r_state <= RUN;
              r_slot  <= w_first;
              r_left  <= r_cnt[w_first];
            end else begin
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (w_zero) begin
            if (!w_last) begin
              r_left <= r_left - CNT_W'(1);
            end else if (w_nxt_ok) begin
              r_slot <= w_nxt;
              r_left <= r_cnt[w_nxt];
            end else begin
              r_state <= DONE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tick = (r_state == RUN) && w_zero && !stop;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign slot = r_slot;
endmodule
